// File: rtl/id_ex_pipe.sv
// Decode->execute pipeline register with load-use bubbles, multi-beat vector
// hold and branch-flush squash.
// Optional feature: define ID_EX_PERF_EN to build the stall/flush counters;
// without it perf_stall and perf_flush are tied to zero.
module id_ex_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned VEC_BEATS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  output logic                               id_ready,
  input  logic [15:0]                        ctrl_in,
  input  logic [REG_AW-1:0]                  rs1,
  input  logic [REG_AW-1:0]                  rs2,
  input  logic [REG_AW-1:0]                  rd,
  input  logic [DATA_W-1:0]                  rd1,
  input  logic [DATA_W-1:0]                  rd2,
  input  logic [DATA_W-1:0]                  imm,
  input  logic                               flush,
  input  logic                               ex_ready,
  output logic                               ex_valid,
  output logic [15:0]                        ctrl_out,
  output logic [REG_AW-1:0]                  ex_rs1,
  output logic [REG_AW-1:0]                  ex_rs2,
  output logic [REG_AW-1:0]                  ex_rd,
  output logic [DATA_W-1:0]                  ex_rd1,
  output logic [DATA_W-1:0]                  ex_rd2,
  output logic [DATA_W-1:0]                  ex_imm,
  output logic [$clog2(VEC_BEATS+1)-1:0]     ex_beat,
  output logic                               ex_last,
  output logic [31:0]                        perf_stall,
  output logic [31:0]                        perf_flush
);

  localparam int unsigned BEAT_W = $clog2(VEC_BEATS + 1);
  localparam int unsigned PERF_W = 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VEC_BEATS - 1);
  localparam bit VEC_MULTI = (VEC_BEATS > 1);

  // Control bundle as produced by the control unit, MSB first.
  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src3;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src2;
  } ctrl_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    SCALAR   = 2'd1,
    VEC_BUSY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [REG_AW-1:0]   rs1_q, rs1_d;
  logic [REG_AW-1:0]   rs2_q, rs2_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  ctrl_t ctrl_in_s;
  logic  ex_last_c;
  logic  load_use_c;
  logic  vec_hold_c;
  logic  id_ready_c;

  assign ctrl_in_s = ctrl_t'(ctrl_in);

  // Hazard and handshake decode from the current EX contents.
  always_comb begin
    ex_last_c  = (state_q == SCALAR) ||
                 ((state_q == VEC_BUSY) && (beat_q == LAST_BEAT));
    vec_hold_c = (state_q == VEC_BUSY) && (beat_q < LAST_BEAT);
    load_use_c = valid_q && ctrl_q.mem_read && ex_last_c && id_valid &&
                 ((rd_q == rs1) || (rd_q == rs2));
    id_ready_c = flush || (ex_ready && !load_use_c && !vec_hold_c);
  end

  // Next-state: flush, freeze, vector hold, bubble, capture or retire.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    beat_d  = beat_q;

    if (flush) begin
      state_d = EMPTY;
      valid_d = 1'b0;
      ctrl_d  = '0;
      beat_d  = '0;
    end else if (!ex_ready) begin
      state_d = state_q;
    end else if (vec_hold_c) begin
      beat_d = beat_q + BEAT_W'(1);
    end else if (load_use_c || !id_valid) begin
      state_d = EMPTY;
      valid_d = 1'b0;
      ctrl_d  = '0;
      beat_d  = '0;
    end else begin
      state_d = (ctrl_in_s.vector_op && VEC_MULTI) ? VEC_BUSY : SCALAR;
      valid_d = 1'b1;
      ctrl_d  = ctrl_in_s;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = rd;
      rd1_d   = rd1;
      rd2_d   = rd2;
      imm_d   = imm;
      beat_d  = '0;
    end
  end

  // EX stage registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      beat_q  <= beat_d;
    end
  end

  assign id_ready = id_ready_c;
  assign ex_last  = ex_last_c;
  assign ex_valid = valid_q;
  assign ctrl_out = ctrl_q;
  assign ex_rs1   = rs1_q;
  assign ex_rs2   = rs2_q;
  assign ex_rd    = rd_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_beat  = beat_q;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  // Stall counts decode cycles blocked while downstream is moving.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (id_valid && !id_ready_c && !flush && ex_ready) begin
      perf_stall_d = perf_stall_q + PERF_W'(1);
    end
    if (flush) begin
      perf_flush_d = perf_flush_q + PERF_W'(1);
    end
  end

  // Counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = PERF_W'(0);
  assign perf_flush = PERF_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios then random traffic,
// all checked against an instruction-level model of the EX slot.
module tb_id_ex_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned VB = 4;
  localparam int unsigned BW = $clog2(VB + 1);
`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [15:0] C_LOAD = 16'h1A10;
  localparam logic [15:0] C_ADD  = 16'h0014;
  localparam logic [15:0] C_SUB  = 16'h0019;
  localparam logic [15:0] C_VEC  = 16'h0120;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  logic [15:0]   ctrl_in;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] rd1, rd2, imm;
  logic          flush;
  logic          ex_ready;
  logic          ex_valid;
  logic [15:0]   ctrl_out;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [BW-1:0] ex_beat;
  logic          ex_last;
  logic [31:0]   perf_stall, perf_flush;

  int checks = 0;
  int errors = 0;

  // Model of the EX slot: one instruction record plus the beat it is on.
  bit          m_live;
  logic [15:0] m_ctrl;
  logic [AW-1:0] m_rs1, m_rs2, m_rd;
  logic [DW-1:0] m_rd1, m_rd2, m_imm;
  int          m_beat;
  int unsigned m_pstall;
  int unsigned m_pflush;

  id_ex_pipe #(.DATA_W(DW), .REG_AW(AW), .VEC_BEATS(VB)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .ctrl_in(ctrl_in), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rd1(rd1), .rd2(rd2), .imm(imm), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ctrl_out(ctrl_out),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_beat(ex_beat), .ex_last(ex_last),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Number of EX cycles the op in the slot occupies.
  function automatic int op_beats();
    return (m_ctrl[8] && VB > 1) ? int'(VB) : 1;
  endfunction

  function automatic bit exp_last();
    return m_live && (m_beat == op_beats() - 1);
  endfunction

  function automatic bit exp_hazard();
    return exp_last() && m_ctrl[11] && id_valid && (m_rd == rs1 || m_rd == rs2);
  endfunction

  function automatic bit exp_busy();
    return m_live && (m_beat < op_beats() - 1);
  endfunction

  function automatic bit exp_ready();
    return flush || (ex_ready && !exp_hazard() && !exp_busy());
  endfunction

  task automatic drive(input logic v, input logic [15:0] c, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] d,
                       input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                       input logic [DW-1:0] im, input logic fl, input logic er);
    id_valid = v; ctrl_in = c; rs1 = a1; rs2 = a2; rd = d;
    rd1 = x1; rd2 = x2; imm = im; flush = fl; ex_ready = er;
  endtask

  task automatic check_all();
    chk("ex_valid", 32'(ex_valid), 32'(m_live));
    chk("ctrl_out", 32'(ctrl_out), m_live ? 32'(m_ctrl) : 32'd0);
    chk("ex_beat", 32'(ex_beat), 32'(m_beat));
    chk("ex_last", 32'(ex_last), 32'(exp_last()));
    chk("id_ready", 32'(id_ready), 32'(exp_ready()));
    if (m_live) begin
      chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_rd1", ex_rd1, m_rd1);
      chk("ex_rd2", ex_rd2, m_rd2);
      chk("ex_imm", ex_imm, m_imm);
    end
    chk("perf_stall", perf_stall, m_pstall);
    chk("perf_flush", perf_flush, m_pflush);
  endtask

  task automatic cyc(input logic v, input logic [15:0] c, input logic [AW-1:0] a1,
                     input logic [AW-1:0] a2, input logic [AW-1:0] d,
                     input logic fl, input logic er);
    drive(v, c, a1, a2, d, $urandom, $urandom, $urandom, fl, er);
    #1;
    check_all();
  endtask

  // Advance the model by one clock using the inputs now applied, then wait.
  task automatic tick();
    bit hz, busy, rdy;
    hz   = exp_hazard();
    busy = exp_busy();
    rdy  = exp_ready();
    if (rst) begin
      m_live = 0; m_beat = 0; m_ctrl = '0; m_pstall = 0; m_pflush = 0;
    end else begin
      if (PERF && id_valid && !rdy && !flush && ex_ready) m_pstall++;
      if (flush) begin
        if (PERF) m_pflush++;
        m_live = 0; m_beat = 0;
      end else if (!ex_ready) begin
        m_beat = m_beat;
      end else if (busy) begin
        m_beat++;
      end else if (hz || !id_valid) begin
        m_live = 0; m_beat = 0;
      end else begin
        m_live = 1; m_beat = 0; m_ctrl = ctrl_in;
        m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
        m_rd1 = rd1; m_rd2 = rd2; m_imm = imm;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_live = 0; m_beat = 0; m_ctrl = '0; m_pstall = 0; m_pflush = 0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;

    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
      chk("rst_ex_beat", 32'(ex_beat), 32'd0);
      chk("rst_ex_rd1", ex_rd1, 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
    end
    rst = 1'b0;

    // 2: back-to-back scalar ALU ops
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i % 2 == 0) ? C_ADD : C_SUB, 4'(i), 4'(i + 1), 4'(i + 8), 1'b0, 1'b1);
      chk("s2_id_ready", 32'(id_ready), 32'd1);
      if (i > 0) chk("s2_ex_last", 32'(ex_last), 32'd1);
      tick();
    end

    // 3: load rd=5 followed by a dependent add
    cyc(1'b1, C_LOAD, 4'd2, 4'd0, 4'd5, 1'b0, 1'b1);
    tick();
    cyc(1'b1, C_ADD, 4'd5, 4'd3, 4'd6, 1'b0, 1'b1);
    chk("s3_stall_ready", 32'(id_ready), 32'd0);
    tick();
    cyc(1'b1, C_ADD, 4'd5, 4'd3, 4'd6, 1'b0, 1'b1);
    chk("s3_bubble_ctrl", 32'(ctrl_out), 32'd0);
    chk("s3_bubble_valid", 32'(ex_valid), 32'd0);
    tick();
    cyc(1'b0, C_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("s3_add_rs1", 32'(ex_rs1), 32'd5);
    chk("s3_add_ctrl", 32'(ctrl_out), 32'(C_ADD));
    tick();

    // 6: flush after the load-use scenario
    cyc(1'b1, C_ADD, 4'd1, 4'd1, 4'd1, 1'b1, 1'b1);
    tick();
    cyc(1'b0, C_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("s6_perf_stall", perf_stall, PERF ? 32'd1 : 32'd0);
    chk("s6_perf_flush", perf_flush, PERF ? 32'd1 : 32'd0);
    tick();

    // 4: vector op walks all beats, decode held until the last
    cyc(1'b1, C_VEC, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
    tick();
    for (int b = 0; b < int'(VB); b++) begin
      cyc(1'b1, C_ADD, 4'd9, 4'd10, 4'd11, 1'b0, 1'b1);
      chk("s4_beat", 32'(ex_beat), 32'(b));
      chk("s4_ready", 32'(id_ready), 32'(b == int'(VB) - 1));
      chk("s4_last", 32'(ex_last), 32'(b == int'(VB) - 1));
      tick();
    end

    // 5: flush on vector beat 1 while EX is frozen
    cyc(1'b1, C_VEC, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
    tick();
    cyc(1'b0, C_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    cyc(1'b1, C_ADD, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk("s5_beat1", 32'(ex_beat), 32'd1);
    tick();
    cyc(1'b0, C_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("s5_valid", 32'(ex_valid), 32'd0);
    chk("s5_beat", 32'(ex_beat), 32'd0);
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] c;
      c = 16'($urandom);
      c[8] = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cyc(($urandom_range(0, 4) != 0), c, 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
